regfile_read_arbiter: RTL and testbench
=======================================

// Module: regfile_read_arbiter
// PURPOSE
// Shares the register file's two combinational read ports between two requesters.
// The decode stage is the primary requester and owns the ports by default.
// A debug/host requester uses a valid/ready request and response handshake.
// The block sits between the decode stage, the debug port and the register file.
// It steals the ports from decode for at most one cycle per debug read, raising a stall that is ORed into the decode stall.
// PARAMETERS
// REG_ID_WIDTH    5   width of a register id
// DATA_WIDTH      32  width of register data
// MAX_WAIT        8   max cycles a pending debug read defers to decode before stealing (>=1)
// WAIT_CNT_WIDTH  4   wait counter width; must hold MAX_WAIT-1
// PORTS
// clock         in   1             single clock, rising edge
// reset         in   1             asynchronous, active-low (0 = in reset)
// pipeReadValid in   1             decode needs the read ports this cycle (valid, non-bubbled instruction)
// pipeReadId1   in   REG_ID_WIDTH  decode read id, port 1
// pipeReadId2   in   REG_ID_WIDTH  decode read id, port 2
// pipeData1     out  DATA_WIDTH    rfData1 passed through to decode
// pipeData2     out  DATA_WIDTH    rfData2 passed through to decode
// pipeStall     out  1             ports stolen this cycle; decode must stall
// dbgReqValid   in   1             debug read request valid
// dbgReqReady   out  1             arbiter accepts a debug request
// dbgReqId1     in   REG_ID_WIDTH  debug read id, port 1
// dbgReqId2     in   REG_ID_WIDTH  debug read id, port 2
// dbgRespValid  out  1             debug response valid
// dbgRespReady  in   1             debug consumer accepts the response
// dbgRespData1  out  DATA_WIDTH    captured data, port 1
// dbgRespData2  out  DATA_WIDTH    captured data, port 2
// rfReadId1     out  REG_ID_WIDTH  read id to register file, port 1
// rfReadId2     out  REG_ID_WIDTH  read id to register file, port 2
// rfData1       in   DATA_WIDTH    register file read data, port 1 (combinational)
// rfData2       in   DATA_WIDTH    register file read data, port 2 (combinational)
// stealCount    out  16            steal statistics counter (see CONFIGURATION)
// BEHAVIOUR
// - FSM states: IDLE, PENDING, RESP. Reset forces IDLE immediately (asynchronous).
// - Reset values:
//   - state=IDLE, waitCnt=0, dbgRespValid=0, dbgRespData*=0, stealCount=0.
//   - dbgReqReady=1 once reset deasserts.
// - IDLE:
//   - dbgReqReady=1.
//   - On dbgReqValid&&dbgReqReady: latch dbgReqId1/2, set waitCnt=0, go to PENDING.
// - PENDING:
//   - dbgReqReady=0.
//   - Grant condition: grant = !pipeReadValid || waitCnt==MAX_WAIT-1.
//   - On grant: rfReadId* = latched ids; rfData* captured into dbgRespData* at the edge; go to RESP.
//   - Else: waitCnt++ (cannot exceed MAX_WAIT-1).
//   - pipeStall = grant && pipeReadValid (combinational). It is never asserted outside PENDING.
// - RESP:
//   - dbgRespValid=1; dbgRespData* held stable.
//   - dbgReqReady=0.
//   - On dbgRespReady: go to IDLE. The next request is accepted no earlier than the following cycle.
// - In all non-grant cycles, rfReadId* = pipeReadId*.
// - pipeData* = rfData* always, with zero latency.
// - Decode sees garbage data only while pipeStall=1.
// - Latency:
//   - Accept to dbgRespValid is 2 cycles minimum.
//   - It is MAX_WAIT+1 cycles maximum under continuous pipeReadValid.
// - Starvation bound: decode loses at most 1 cycle per debug read.
// - dbgReqValid held high in RESP is ignored until IDLE.
// - pipeReadValid toggling in PENDING: grant fires on the first low cycle, with no stall.
// - Reset mid-PENDING/RESP: request and response are discarded, and no stall is asserted after reset.
// CONFIGURATION
// REGFILE_ARB_STATS_EN:
// - Defined: stealCount increments on every cycle with pipeStall=1 and saturates at 16'hFFFF.
// - Undefined: stealCount is tied to 0 and no counter logic is built.
// TESTING
// - No debug traffic, pipeReadValid=1, ids 3/4: rfReadId=3/4 every cycle, pipeStall never 1.
// - Debug ids 5/6 with pipeReadValid=0: accepted in cycle 0, granted in cycle 1.
//   dbgRespValid=1 in cycle 2 with data = rf[5]/rf[6], and no pipeStall.
// - MAX_WAIT=8, debug req with pipeReadValid stuck at 1: 7 deferral cycles, then 1 cycle pipeStall=1.
//   rfReadId equals the debug ids in that cycle, and dbgRespValid rises in cycle 9.
// - dbgRespReady held 0 for 5 cycles in RESP: dbgRespValid and data stay stable, dbgReqReady=0.
//   A new dbgReqValid is not accepted until the cycle after dbgRespReady=1.
// - reset driven low asynchronously mid-PENDING at wait count 4: outputs go to reset values at once.
//   pipeStall=0, and the request is dropped after release.
// - With REGFILE_ARB_STATS_EN, 3 stolen reads: stealCount=3. Without the macro: stealCount=0.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
// Arbitrates the register file's two read ports between decode (default owner) and a debug requester.
// Optional steal statistics counter built only when REGFILE_ARB_STATS_EN is defined.
module regfile_read_arbiter #(
  parameter int unsigned REG_ID_WIDTH   = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_WAIT       = 8,
  parameter int unsigned WAIT_CNT_WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pipeReadValid,
  input  logic [REG_ID_WIDTH-1:0] pipeReadId1,
  input  logic [REG_ID_WIDTH-1:0] pipeReadId2,
  output logic [DATA_WIDTH-1:0]   pipeData1,
  output logic [DATA_WIDTH-1:0]   pipeData2,
  output logic                    pipeStall,
  input  logic                    dbgReqValid,
  output logic                    dbgReqReady,
  input  logic [REG_ID_WIDTH-1:0] dbgReqId1,
  input  logic [REG_ID_WIDTH-1:0] dbgReqId2,
  output logic                    dbgRespValid,
  input  logic                    dbgRespReady,
  output logic [DATA_WIDTH-1:0]   dbgRespData1,
  output logic [DATA_WIDTH-1:0]   dbgRespData2,
  output logic [REG_ID_WIDTH-1:0] rfReadId1,
  output logic [REG_ID_WIDTH-1:0] rfReadId2,
  input  logic [DATA_WIDTH-1:0]   rfData1,
  input  logic [DATA_WIDTH-1:0]   rfData2,
  output logic [15:0]             stealCount
);

  typedef enum logic [1:0] {IDLE, PENDING, RESP} state_t;

  localparam logic [WAIT_CNT_WIDTH-1:0] LP_WAIT_LAST = WAIT_CNT_WIDTH'(MAX_WAIT - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [REG_ID_WIDTH-1:0]   r_id1;
  logic [REG_ID_WIDTH-1:0]   r_id2;
  logic [WAIT_CNT_WIDTH-1:0] r_wait_cnt;
  logic [DATA_WIDTH-1:0]     r_data1;
  logic [DATA_WIDTH-1:0]     r_data2;
  logic                      w_grant;
  logic                      w_accept;

  assign pipeData1    = rfData1;
  assign pipeData2    = rfData2;
  assign dbgRespData1 = r_data1;
  assign dbgRespData2 = r_data2;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_accept     = 1'b0;
    dbgReqReady  = 1'b0;
    dbgRespValid = 1'b0;
    pipeStall    = 1'b0;
    rfReadId1    = pipeReadId1;
    rfReadId2    = pipeReadId2;
    case (r_state)
      IDLE: begin
        dbgReqReady = 1'b1;
        w_accept    = dbgReqValid;
        if (dbgReqValid) w_state_nxt = PENDING;
      end
      PENDING: begin
        // Take the ports on any decode bubble, or unconditionally once the wait budget is spent.
        w_grant = !pipeReadValid || (r_wait_cnt == LP_WAIT_LAST);
        if (w_grant) begin
          rfReadId1   = r_id1;
          rfReadId2   = r_id2;
          pipeStall   = pipeReadValid;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        dbgRespValid = 1'b1;
        if (dbgRespReady) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_id1      <= '0;
      r_id2      <= '0;
      r_wait_cnt <= '0;
      r_data1    <= '0;
      r_data2    <= '0;
    end else begin
      if (w_accept) begin
        r_id1      <= dbgReqId1;
        r_id2      <= dbgReqId2;
        r_wait_cnt <= '0;
      end else if (r_state == PENDING && !w_grant) begin
        r_wait_cnt <= r_wait_cnt + WAIT_CNT_WIDTH'(1);
      end
      if (w_grant) begin
        r_data1 <= rfData1;
        r_data2 <= rfData2;
      end
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] r_steal_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                               r_steal_cnt <= '0;
    else if (pipeStall && r_steal_cnt != '1) r_steal_cnt <= r_steal_cnt + 16'd1;
  end

  assign stealCount = r_steal_cnt;
`else
  assign stealCount = '0;
`endif

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter; debug responses are checked by a queue-based scoreboard monitor.
module tb_regfile_read_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        pipeReadValid;
  logic [4:0]  pipeReadId1, pipeReadId2;
  logic [31:0] pipeData1, pipeData2;
  logic        pipeStall;
  logic        dbgReqValid, dbgReqReady;
  logic [4:0]  dbgReqId1, dbgReqId2;
  logic        dbgRespValid, dbgRespReady;
  logic [31:0] dbgRespData1, dbgRespData2;
  logic [4:0]  rfReadId1, rfReadId2;
  logic [31:0] rfData1, rfData2;
  logic [15:0] stealCount;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

`ifdef REGFILE_ARB_STATS_EN
  localparam logic [31:0] EXP_STEAL = 32'd3;
`else
  localparam logic [31:0] EXP_STEAL = 32'd0;
`endif

  always #5 clock = ~clock;

  // Register file model: rf[id] = 0xC0DE_<id><id> (id in a byte each)
  assign rfData1 = {16'hC0DE, 3'b000, rfReadId1, 3'b000, rfReadId1};
  assign rfData2 = {16'hC0DE, 3'b000, rfReadId2, 3'b000, rfReadId2};

  regfile_read_arbiter #(
    .REG_ID_WIDTH  (5),
    .DATA_WIDTH    (32),
    .MAX_WAIT      (8),
    .WAIT_CNT_WIDTH(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pipeReadValid(pipeReadValid),
    .pipeReadId1  (pipeReadId1),
    .pipeReadId2  (pipeReadId2),
    .pipeData1    (pipeData1),
    .pipeData2    (pipeData2),
    .pipeStall    (pipeStall),
    .dbgReqValid  (dbgReqValid),
    .dbgReqReady  (dbgReqReady),
    .dbgReqId1    (dbgReqId1),
    .dbgReqId2    (dbgReqId2),
    .dbgRespValid (dbgRespValid),
    .dbgRespReady (dbgRespReady),
    .dbgRespData1 (dbgRespData1),
    .dbgRespData2 (dbgRespData2),
    .rfReadId1    (rfReadId1),
    .rfReadId2    (rfReadId2),
    .rfData1      (rfData1),
    .rfData2      (rfData2),
    .stealCount   (stealCount)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: every completed response handshake is matched against the queue head.
  always @(negedge clock) begin
    if (reset && dbgRespValid && dbgRespReady) begin
      if (sb_q.size() == 0) begin
        chk("resp_unexpected", {dbgRespData1}, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("resp_data1", dbgRespData1, e[63:32]);
        chk("resp_data2", dbgRespData2, e[31:0]);
      end
    end
  end

  logic [4:0]  t_id1 [3] = '{5'd1, 5'd15, 5'd30};
  logic [4:0]  t_id2 [3] = '{5'd2, 5'd16, 5'd31};
  logic [63:0] t_exp [3] = '{64'hC0DE0101_C0DE0202, 64'hC0DE0F0F_C0DE1010, 64'hC0DE1E1E_C0DE1F1F};

  initial begin
    reset = 1'b0; pipeReadValid = 1'b0; pipeReadId1 = '0; pipeReadId2 = '0;
    dbgReqValid = 1'b0; dbgReqId1 = '0; dbgReqId2 = '0; dbgRespReady = 1'b1;
    #7;
    chk("rst_resp_valid", 32'(dbgRespValid), 32'd0);
    chk("rst_resp_data1", dbgRespData1, 32'd0);
    chk("rst_steal", 32'(stealCount), 32'd0);
    chk("rst_stall", 32'(pipeStall), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    cyc();

    // Decode-only traffic: ports follow decode ids, no stall
    pipeReadValid = 1'b1; pipeReadId1 = 5'd3; pipeReadId2 = 5'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t1_rfid1", 32'(rfReadId1), 32'd3);
      chk("t1_rfid2", 32'(rfReadId2), 32'd4);
      chk("t1_stall", 32'(pipeStall), 32'd0);
      chk("t1_pdata1", pipeData1, 32'hC0DE0303);
      cyc();
    end

    // Debug read during a decode bubble: grant in cycle 1, response in cycle 2
    pipeReadValid = 1'b0; dbgReqValid = 1'b1; dbgReqId1 = 5'd5; dbgReqId2 = 5'd6;
    sb_q.push_back(64'hC0DE0505_C0DE0606);
    @(negedge clock);
    chk("t2_req_ready0", 32'(dbgReqReady), 32'd1);
    cyc();
    dbgReqValid = 1'b0;
    @(negedge clock);
    chk("t2_req_ready1", 32'(dbgReqReady), 32'd0);
    chk("t2_rfid1", 32'(rfReadId1), 32'd5);
    chk("t2_rfid2", 32'(rfReadId2), 32'd6);
    chk("t2_stall", 32'(pipeStall), 32'd0);
    chk("t2_valid1", 32'(dbgRespValid), 32'd0);
    cyc();
    @(negedge clock);
    chk("t2_valid2", 32'(dbgRespValid), 32'd1);
    cyc();
    @(negedge clock);
    chk("t2_valid3", 32'(dbgRespValid), 32'd0);
    chk("t2_req_ready3", 32'(dbgReqReady), 32'd1);
    cyc();

    // Decode busy every cycle: 7 deferrals, steal in cycle 8, response in cycle 9
    pipeReadValid = 1'b1; dbgReqValid = 1'b1; dbgReqId1 = 5'd9; dbgReqId2 = 5'd10;
    sb_q.push_back(64'hC0DE0909_C0DE0A0A);
    @(negedge clock);
    cyc();
    dbgReqValid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      chk("t3_defer_stall", 32'(pipeStall), 32'd0);
      chk("t3_defer_rfid1", 32'(rfReadId1), 32'd3);
      chk("t3_defer_valid", 32'(dbgRespValid), 32'd0);
      cyc();
    end
    @(negedge clock);
    chk("t3_steal_stall", 32'(pipeStall), 32'd1);
    chk("t3_steal_rfid1", 32'(rfReadId1), 32'd9);
    chk("t3_steal_rfid2", 32'(rfReadId2), 32'd10);
    cyc();
    @(negedge clock);
    chk("t3_valid9", 32'(dbgRespValid), 32'd1);
    chk("t3_stall9", 32'(pipeStall), 32'd0);
    cyc();

    // Response back-pressure; a request held during RESP waits for IDLE
    pipeReadValid = 1'b0; dbgRespReady = 1'b0;
    dbgReqValid = 1'b1; dbgReqId1 = 5'd7; dbgReqId2 = 5'd8;
    sb_q.push_back(64'hC0DE0707_C0DE0808);
    @(negedge clock);
    cyc();
    dbgReqValid = 1'b0;
    @(negedge clock);
    cyc();
    dbgReqValid = 1'b1; dbgReqId1 = 5'd11; dbgReqId2 = 5'd12;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("t4_hold_valid", 32'(dbgRespValid), 32'd1);
      chk("t4_hold_data1", dbgRespData1, 32'hC0DE0707);
      chk("t4_hold_data2", dbgRespData2, 32'hC0DE0808);
      chk("t4_hold_ready", 32'(dbgReqReady), 32'd0);
      cyc();
    end
    dbgRespReady = 1'b1;
    sb_q.push_back(64'hC0DE0B0B_C0DE0C0C);
    @(negedge clock);
    chk("t4_release_ready", 32'(dbgReqReady), 32'd0);
    cyc();
    @(negedge clock);
    chk("t4_idle_ready", 32'(dbgReqReady), 32'd1);
    cyc();
    dbgReqValid = 1'b0;
    @(negedge clock);
    chk("t4_grant_rfid1", 32'(rfReadId1), 32'd11);
    cyc();
    @(negedge clock);
    chk("t4_valid", 32'(dbgRespValid), 32'd1);
    cyc();

    // Asynchronous reset while pending at wait count 4: request is dropped
    pipeReadValid = 1'b1; dbgReqValid = 1'b1; dbgReqId1 = 5'd13; dbgReqId2 = 5'd14;
    cyc();
    dbgReqValid = 1'b0;
    repeat (4) cyc();
    #2;
    reset = 1'b0;
    #1;
    chk("t5_stall", 32'(pipeStall), 32'd0);
    chk("t5_valid", 32'(dbgRespValid), 32'd0);
    chk("t5_data1", dbgRespData1, 32'd0);
    chk("t5_data2", dbgRespData2, 32'd0);
    chk("t5_steal", 32'(stealCount), 32'd0);
    chk("t5_rfid1", 32'(rfReadId1), 32'd3);
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk("t5_post_stall", 32'(pipeStall), 32'd0);
      chk("t5_post_valid", 32'(dbgRespValid), 32'd0);
      cyc();
    end

    // Three stolen reads under continuous decode traffic
    for (int r = 0; r < 3; r++) begin
      bit done;
      done = 1'b0;
      dbgReqValid = 1'b1; dbgReqId1 = t_id1[r]; dbgReqId2 = t_id2[r];
      sb_q.push_back(t_exp[r]);
      cyc();
      dbgReqValid = 1'b0;
      for (int k = 0; k < 12 && !done; k++) begin
        @(negedge clock);
        if (dbgRespValid) done = 1'b1;
        cyc();
      end
      chk("t6_resp_timeout", 32'(done), 32'd1);
    end
    @(negedge clock);
    chk("t6_steal_count", 32'(stealCount), EXP_STEAL);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
